// File: rtl/mul_shift_add_fsm.sv
// rtl/mul_shift_add_fsm.sv - unsigned shift-and-add multiplier FSM (optional MUL_EARLY_EXIT_EN early exit)
module mul_shift_add_fsm #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic [2*N-1:0]   product,
    output logic             ready,
    output logic             busy
);
    localparam int IW = $clog2(N + 1);

    typedef enum logic [2:0] {
        ESPERA  = 3'd0,
        INICIO  = 3'd1,
        TESTA   = 3'd2,
        SOMA    = 3'd3,
        DESLOCA = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [N:0]      a;
    logic [N-1:0]    q;
    logic [N-1:0]    m;
    logic [IW-1:0]   i;
    logic [IW-1:0]   i_inc;
    logic            last;

    assign i_inc   = i + 1'b1;
    assign last    = (i_inc == IW'(N));
    assign product = {a[N-1:0], q};
    assign busy    = (state != ESPERA);

`ifdef MUL_EARLY_EXIT_EN
    // R tracks the multiplier bits still to be consumed; once empty the
    // remaining iterations would only shift, so they are folded into one edge.
    logic [N-1:0]    r;
    logic            r_zero;
    logic [2*N:0]    aq_skip;
    assign r_zero  = (r == '0);
    assign aq_skip = {a, q} >> (IW'(N) - i);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ESPERA;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = ESPERA;
        case (state)
            ESPERA:  state_nx = start ? INICIO : ESPERA;
            INICIO:  state_nx = TESTA;
            TESTA: begin
`ifdef MUL_EARLY_EXIT_EN
                if (r_zero)
                    state_nx = ESPERA;
                else
`endif
                state_nx = q[0] ? SOMA : DESLOCA;
            end
            SOMA:    state_nx = DESLOCA;
            DESLOCA: state_nx = last ? ESPERA : TESTA;
            default: state_nx = ESPERA;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a     <= '0;
            q     <= '0;
            m     <= '0;
            i     <= '0;
            ready <= 1'b0;
`ifdef MUL_EARLY_EXIT_EN
            r     <= '0;
`endif
        end else begin
            case (state)
                ESPERA: begin
                    ready <= 1'b0;
                end
                INICIO: begin
                    a <= '0;
                    q <= multiplier;
                    m <= multiplicand;
                    i <= '0;
`ifdef MUL_EARLY_EXIT_EN
                    r <= multiplier;
`endif
                end
                TESTA: begin
`ifdef MUL_EARLY_EXIT_EN
                    if (r_zero) begin
                        {a, q} <= aq_skip;
                        ready  <= 1'b1;
                    end
`endif
                end
                SOMA: begin
                    a <= a + {1'b0, m};
                end
                DESLOCA: begin
                    {a, q} <= {1'b0, a, q[N-1:1]};
                    i      <= i_inc;
`ifdef MUL_EARLY_EXIT_EN
                    r      <= r >> 1;
`endif
                    if (last) begin
                        ready <= 1'b1;
                    end
                end
                default: begin
                    ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_shift_add_fsm.sv
// tb/tb_mul_shift_add_fsm.sv - self-checking bench for mul_shift_add_fsm (N=8)
module tb_mul_shift_add_fsm;
    localparam int N = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [N-1:0]     multiplicand = '0;
    logic [N-1:0]     multiplier = '0;
    logic [2*N-1:0]   product;
    logic             ready;
    logic             busy;

    int checks = 0;
    int errors = 0;

    mul_shift_add_fsm #(.N(N)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .ready        (ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Edge count from the start-sampling edge through the ready edge: two setup
    // edges, then per bit one test edge, one shift edge and an add edge for ones.
    function automatic int exp_latency(input int qv);
        int lat;
        lat = 2;
        for (int b = 0; b < N; b++) begin
`ifdef MUL_EARLY_EXIT_EN
            if ((qv >> b) == 0) begin
                lat += 1;
                return lat;
            end
`endif
            lat += 2 + ((qv >> b) & 1);
        end
        return lat;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 1;
        while (!ready && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
            if (!ready) check("busy_during_op", {31'd0, busy}, 32'd1);
        end
        if (!ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input int mv, input int qv, input string tag);
        int cnt;
        @(negedge clk);
        multiplicand = mv[N-1:0];
        multiplier   = qv[N-1:0];
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_ready(cnt);
        check({tag, "_product"}, {16'd0, product}, (mv * qv) & 32'hFFFF);
        check({tag, "_latency"}, cnt, exp_latency(qv));
        check({tag, "_idle_at_ready"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_ready_one_cycle"}, {31'd0, ready}, 32'd0);
        check({tag, "_product_hold"}, {16'd0, product}, (mv * qv) & 32'hFFFF);
    endtask

    initial begin
        int cnt;
        int pulses;
        int mv;
        int qv;
        logic [15:0] seen;

        #1;
        check("reset_product", {16'd0, product}, 32'd0);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        do_op(13, 11, "m13x11");
        do_op(255, 255, "m255x255");
        do_op(200, 0, "m200x0");
        do_op(1, 1, "m1x1");
        do_op(255, 128, "m255x128");

        for (int k = 0; k < 12; k++) begin
            do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "rand");
        end

        // Reset in the middle of a long operation.
        @(negedge clk);
        multiplicand = 8'd255;
        multiplier   = 8'd255;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_product", {16'd0, product}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_hold_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_start_after_reset", {31'd0, busy}, 32'd0);
        do_op(3, 5, "m3x5_after_reset");

        // start and operand changes while busy are ignored.
        @(negedge clk);
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        multiplicand = 8'd100;
        multiplier   = 8'd200;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        seen   = '0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                pulses++;
                seen = product;
            end
        end
        check("busy_start_pulses", pulses, 32'd1);
        check("busy_start_product", {16'd0, seen}, 32'd63);

        // start held high: back-to-back operations.
        @(negedge clk);
        multiplicand = 8'd6;
        multiplier   = 8'd7;
        start        = 1'b1;
        for (int p = 0; p < 3; p++) begin
            cnt = 0;
            while (!(ready && cnt > 1) && cnt < 100) begin
                @(posedge clk);
                #1;
                cnt++;
                if (cnt == 1) begin
                    check("held_ready_drop", {31'd0, ready}, 32'd0);
                    check("held_busy_next", {31'd0, busy}, 32'd1);
                end
            end
            if (!ready) check("held_timeout", 32'd0, 32'd1);
            check("held_product", {16'd0, product}, 32'd42);
            check("held_latency", cnt, exp_latency(7));
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check("held_final_ready_drop", {31'd0, ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("held_final_idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
